// File: rtl/mbscore_fetch.sv
// MBScore fetch stage: PC/IR ownership, req/ack instruction-memory access, jr/jump/branch redirects.
// Optional WAIT watchdog enabled by defining MBSCORE_FETCH_TIMEOUT_EN.
module mbscore_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic        halt,
    input  logic        jr_en,
    input  logic [31:0] rs_data,
    input  logic        jump_en,
    input  logic [25:0] jump_addr,
    input  logic        branch_en,
    input  logic [15:0] imm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        halted,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

    state_t      state;
    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] eff_pc;
    logic        pend_tgt_v;
    logic [31:0] pend_tgt;
    logic        pend_halt;

    assign pc_plus4 = pc + 32'd4;
    assign busy     = (state == WAIT);
    assign halted   = (state == HALTED);

    always_comb begin
        redir = jr_en | jump_en | branch_en;
        if (jr_en)        redir_tgt = rs_data;
        else if (jump_en) redir_tgt = {pc_plus4[31:28], jump_addr, 2'b00};
        else              redir_tgt = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        redir_tgt[1:0] = 2'b00;
        eff_pc = redir ? redir_tgt : pc;
    end

`ifdef MBSCORE_FETCH_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] to_cnt;
`else
    // No watchdog: the error flag can never set.
    assign fetch_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_addr  <= RESET_PC;
            imem_req   <= 1'b0;
            inst       <= 32'h0;
            inst_valid <= 1'b0;
            pend_tgt_v <= 1'b0;
            pend_tgt   <= 32'h0;
            pend_halt  <= 1'b0;
`ifdef MBSCORE_FETCH_TIMEOUT_EN
            to_cnt     <= '0;
            fetch_err  <= 1'b0;
`endif
        end else begin
            inst_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (fetch) begin
                        imem_req   <= 1'b1;
                        imem_addr  <= eff_pc;
                        pend_tgt_v <= 1'b0;
                        pend_halt  <= 1'b0;
                        state      <= WAIT;
`ifdef MBSCORE_FETCH_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end else if (redir) begin
                        pc <= redir_tgt;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        // Requests arriving with the ack count as the latest ones.
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                        pc         <= redir ? redir_tgt : (pend_tgt_v ? pend_tgt : imem_addr + 32'd4);
                        pend_tgt_v <= 1'b0;
                        pend_halt  <= 1'b0;
                        state      <= (halt || pend_halt) ? HALTED : IDLE;
                    end else begin
                        if (redir) begin
                            pend_tgt   <= redir_tgt;
                            pend_tgt_v <= 1'b1;
                        end
                        if (halt) pend_halt <= 1'b1;
`ifdef MBSCORE_FETCH_TIMEOUT_EN
                        if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            imem_req   <= 1'b0;
                            fetch_err  <= 1'b1;
                            pend_tgt_v <= 1'b0;
                            pend_halt  <= 1'b0;
                            state      <= HALTED;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                end
                HALTED: begin
                    imem_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mbscore_fetch.md
# mbscore_fetch

Instruction-fetch stage of the MBScore multi-cycle core, upstream of the control FSM. Owns the program counter and instruction register, issues requests to instruction memory over a req/ack handshake tolerant of variable latency, and applies jump/branch/jr redirects. It consumes the fetch strobe, halt, and redirect requests from the controller, and supplies the latched instruction that the controller decodes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0
- TIMEOUT_CYCLES, 256, WAIT-state watchdog limit; used only with MBSCORE_FETCH_TIMEOUT_EN

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- fetch  in  1  start one fetch; the controller drives it with its pc_we/IR_we pulse in IF
- halt  in  1  stop fetching after the current access
- jr_en  in  1  redirect: PC <= rs_data
- rs_data  in  32  jr target
- jump_en  in  1  redirect: PC <= {pc_plus4[31:28], jump_addr, 2'b00}
- jump_addr  in  26  J/JAL index field
- branch_en  in  1  redirect: PC <= pc_plus4 + (sign_ext(imm) << 2)
- imm  in  16  branch offset
- imem_req  out  1  memory request, held until ack
- imem_addr  out  32  request address, stable while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- imem_ack  in  1  one-cycle completion
- inst  out  32  instruction register
- inst_valid  out  1  one-cycle pulse: inst updated
- pc  out  32  PC of next fetch
- pc_plus4  out  32  combinational pc+4 (JAL link value)
- busy  out  1  1 in WAIT
- halted  out  1  1 in HALTED
- fetch_err  out  1  sticky memory-timeout flag

## Operation
- FSM states: IDLE, WAIT, HALTED.
- IDLE:
  - halt=1 -> HALTED, with priority over fetch.
  - fetch=1 -> imem_req<=1, imem_addr<=effective PC, -> WAIT.
- Effective PC = the redirect target if a redirect is asserted this cycle, else pc.
- Redirect priority is jr > jump > branch. The target has bits [1:0] forced to 0.
- A redirect in IDLE without fetch updates pc only.
- WAIT:
  - A redirect is captured into a pending-target register, last one wins. fetch is ignored.
  - halt is captured into a pending-halt flag.
  - On imem_ack: inst<=imem_rdata, inst_valid<=1, imem_req<=0, pc<=pending target if set, else imem_addr+4. Pending flags are cleared.
  - After ack: -> HALTED if pending halt is set, else IDLE.
- HALTED: absorbing. Only reset exits it. imem_req=0; fetch and redirects are ignored.
- Arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0. Branch offset sign extends bit 15; imm=16'h8000 gives -131072.
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, inst=0, inst_valid=0, imem_req=0, busy=0, halted=0, fetch_err=0, state IDLE, pending flags cleared.
- Reset asserted mid-WAIT drops imem_req immediately. A late ack after reset is ignored.

## Timing
- fetch sampled at edge N -> imem_req=1 from N+1.
- Ack sampled at edge M (M>=N+1) -> inst/inst_valid/pc updated at M+1. inst_valid is high for exactly one cycle.
- Minimum fetch-to-inst_valid latency is 2 cycles. Back-to-back fetch is accepted in the cycle after inst_valid.
- imem_addr must not change while imem_req=1.
- imem_ack while imem_req=0 is ignored.
- busy and halted are registered state decodes. pc_plus4 is combinational from pc.

## Configuration
- MBSCORE_FETCH_TIMEOUT_EN defined:
  - An 8+-bit counter runs in WAIT.
  - If TIMEOUT_CYCLES consecutive cycles pass without ack: imem_req<=0, fetch_err<=1, -> HALTED. inst and pc are unchanged and no inst_valid pulse is produced.
  - The counter clears on entry to WAIT.
- Not defined: no counter, WAIT lasts indefinitely, fetch_err tied to 0.

## Test plan
- Reset then fetch, ack after 3 cycles with rdata=32'h2008_0005 -> imem_addr=0 while req is high; inst=32'h2008_0005, inst_valid pulse, pc=4.
- pc=32'h0040_0010, jump_en with jump_addr=26'h10_0000 plus fetch in IDLE -> imem_addr=32'h0040_0000. After ack, pc=32'h0040_0004.
- branch_en with imm=16'hFFFE asserted in WAIT at imem_addr=32'h100, also jr_en with rs_data=32'h203 in a later WAIT cycle -> after ack, pc=32'h200 (jr, later wins, low bits cleared).
- pc=32'hFFFF_FFFC, fetch then ack -> pc=0. halt during WAIT -> ack completes, inst_valid pulses, halted=1, later fetch produces no imem_req.
- rst low for 1 cycle mid-WAIT -> imem_req=0 immediately, pc=RESET_PC, a following ack produces no inst_valid.
- With MBSCORE_FETCH_TIMEOUT_EN and no ack for 256 cycles -> fetch_err=1, halted=1, imem_req=0, inst unchanged.
